fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the MIPS pipelined CPU. Owns the PC and issues requests to instruction memory over a req/ack handshake that tolerates variable latency. Fetched words go into a FETCH_DEPTH-entry prefetch FIFO, which feeds the decode stage through a valid/ready interface. A branch/jump redirect flushes the FIFO, squashes any in-flight fetch, and restarts fetching at the new target.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  localparam int INST_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between instruction memory and decode; head is presented
// combinationally, flush empties it in one cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     cpu_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // NOTE: storage is reset as well so the head reads zero out of reset,
  // which is what decode sees on if_inst/if_pc before the first fetch.
  always_ff @(posedge clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block reading the pre-edge values, independent of statement order.
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the req/ack handshake to
// instruction memory and feeds decode from the prefetch FIFO.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    FETCH_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  cpu_rst,
  input  logic                  cpu_en,
  output logic                  inst_ren,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_ack,
  input  logic [DATA_WIDTH-1:0] inst_data,
  input  logic                  redir_valid,
  input  logic [ADDR_WIDTH-1:0] redir_addr,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_inst,
  output logic [ADDR_WIDTH-1:0] if_pc
);

  localparam int CW = $clog2(FETCH_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(FETCH_DEPTH);

  fetch_state_e          state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [ADDR_WIDTH-1:0] req_addr, req_nxt;
  logic [ADDR_WIDTH-1:0] redir_aligned, fetch_from;
  logic                  push, pop, fifo_empty, unused_fifo_full, issue_ok, issue;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           next_occ;
  logic                  unused_redir_bits;

  assign redir_aligned     = {redir_addr[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redir_bits = ^redir_addr[1:0];

  assign inst_ren  = (state != FS_IDLE);
  assign inst_addr = req_addr;
  assign if_valid  = ~fifo_empty;

  // A redirect flushes, so neither a push nor a pop takes effect that cycle.
  assign push = (state == FS_WAIT) & inst_ack & ~redir_valid;
  assign pop  = if_valid & if_ready & ~redir_valid;

  assign next_occ   = {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  assign issue_ok   = cpu_en & (next_occ < DEPTH_LIMIT);
  assign fetch_from = redir_valid ? redir_aligned : pc;

  // NOTE: every variable gets a default before any branch so that no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    req_nxt   = req_addr;
    issue     = 1'b0;
    if (redir_valid) begin
      pc_nxt = redir_aligned;
      if (inst_ren && !inst_ack) begin
        state_nxt = FS_DROP;
      end else begin
        state_nxt = FS_IDLE;
        issue     = cpu_en;
      end
    end else begin
      unique case (state)
        FS_IDLE: issue = issue_ok;
        FS_WAIT, FS_DROP: begin
          if (inst_ack) begin
            state_nxt = FS_IDLE;
            issue     = issue_ok;
          end
        end
        default: state_nxt = FS_IDLE;
      endcase
    end
    if (issue) begin
      state_nxt = FS_WAIT;
      req_nxt   = fetch_from;
      pc_nxt    = fetch_from + ADDR_WIDTH'(INST_BYTES);
    end
  end

  always_ff @(posedge clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state    <= FS_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_nxt;
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FETCH_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .cpu_rst (cpu_rst),
    .push    (push),
    .pop     (pop),
    .flush   (redir_valid),
    .din     ({req_addr, inst_data}),
    .full    (unused_fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    ({if_pc, if_inst})
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run, all scored against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          cpu_rst, cpu_en, inst_ren, inst_ack, redir_valid, if_valid, if_ready;
  logic [AW-1:0] inst_addr, redir_addr, if_pc;
  logic [DW-1:0] inst_data, if_inst;

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FETCH_DEPTH(DEPTH),
    .RESET_PC   (32'h0)
  ) dut (
    .clk        (clk),
    .cpu_rst    (cpu_rst),
    .cpu_en     (cpu_en),
    .inst_ren   (inst_ren),
    .inst_addr  (inst_addr),
    .inst_ack   (inst_ack),
    .inst_data  (inst_data),
    .redir_valid(redir_valid),
    .redir_addr (redir_addr),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_inst    (if_inst),
    .if_pc      (if_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } entry_t;

  entry_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus requested for the next cycle.
  bit            b_en, b_ready, b_redir;
  logic [AW-1:0] b_redir_addr;

  // Memory latency model and expected-stream state.
  int            lat_min, lat_max, wc, cur_lat, acks_seen;
  bit            exp_known, exp_ren, prev_ren, prev_ack, stale;
  logic [AW-1:0] prev_addr, exp_req;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_min = lo;
    lat_max = hi;
    cur_lat = $urandom_range(hi, lo);
  endtask

  task automatic do_reset();
    cpu_rst     = 1'b1;
    cpu_en      = 1'b0;
    inst_ack    = 1'b0;
    inst_data   = '0;
    redir_valid = 1'b0;
    redir_addr  = '0;
    if_ready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ren",   inst_ren,  1'b0);
    check("rst_addr",  inst_addr, 32'h0);
    check("rst_valid", if_valid,  1'b0);
    check("rst_pc",    if_pc,     32'h0);
    check("rst_inst",  if_inst,   32'h0);
    q.delete();
    prev_ren  = 1'b0;
    prev_ack  = 1'b0;
    stale     = 1'b0;
    exp_req   = 32'h0;
    wc        = 0;
    acks_seen = 0;
    b_redir   = 1'b0;
    cur_lat   = $urandom_range(lat_max, lat_min);
    cpu_en    = b_en;
    if_ready  = b_ready;
    cpu_rst   = 1'b0;
    // The first edge after release must launch a fetch whenever enabled.
    exp_known = 1'b1;
    exp_ren   = b_en;
  endtask

  // One cycle: check this cycle's outputs, drive inputs, advance the model.
  task automatic tick();
    entry_t e;
    bit     do_pop;
    @(negedge clk);
    check("if_valid", if_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("if_pc",   if_pc,   q[0].pc);
      check("if_inst", if_inst, q[0].inst);
    end
    if (exp_known) check("inst_ren", inst_ren, exp_ren);
    if (inst_ren) begin
      if (prev_ren && !prev_ack) begin
        check("addr_hold", inst_addr, prev_addr);
      end else begin
        check("fetch_addr", inst_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end
    end
    if (inst_ren) begin
      if (wc >= cur_lat) begin
        inst_ack = 1'b1;
        wc       = 0;
        cur_lat  = $urandom_range(lat_max, lat_min);
        acks_seen++;
      end else begin
        inst_ack = 1'b0;
        wc++;
      end
    end else begin
      inst_ack = 1'b0;
      wc       = 0;
    end
    inst_data   = inst_ack ? mem_word(inst_addr) : $urandom();
    cpu_en      = b_en;
    if_ready    = b_ready;
    redir_valid = b_redir;
    redir_addr  = b_redir ? b_redir_addr : $urandom();
    do_pop      = (q.size() != 0) && b_ready;
    if (b_redir) begin
      q.delete();
      exp_req = {b_redir_addr[AW-1:2], 2'b00};
      stale   = inst_ren && !inst_ack;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (inst_ren && inst_ack) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          e.pc   = inst_addr;
          e.inst = inst_data;
          q.push_back(e);
        end
      end
    end
    exp_known = 1'b1;
    exp_ren   = (inst_ren && !inst_ack) || (b_en && q.size() < DEPTH);
    prev_ren  = inst_ren;
    prev_ack  = inst_ack;
    prev_addr = inst_addr;
    b_redir   = 1'b0;
  endtask

  initial begin
    b_en = 1'b1; b_ready = 1'b1; b_redir = 1'b0; b_redir_addr = '0;
    set_lat(0, 0);

    // Zero-wait streaming: one instruction per cycle from address 0.
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream_valid", if_valid, 1'b1);
      check("stream_pc",    if_pc,    32'(4 * i));
      check("stream_inst",  if_inst,  mem_word(32'(4 * i)));
    end

    // Decode stalled: exactly DEPTH fetches, then one pop reopens issue.
    b_ready = 1'b0;
    do_reset();
    repeat (8) tick();
    check("fill_acks",  acks_seen, 4);
    check("fill_ren",   inst_ren,  1'b0);
    check("fill_valid", if_valid,  1'b1);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    tick();
    check("refill_ren",  inst_ren,  1'b1);
    check("refill_addr", inst_addr, 32'h10);

    // 3-cycle memory, redirect in the second wait cycle.
    set_lat(3, 3);
    b_ready = 1'b1;
    do_reset();
    tick();
    b_redir = 1'b1; b_redir_addr = 32'h100;
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      if (inst_ack) break;
    end
    check("drop_ack", inst_ack, 1'b1);
    tick();
    check("redir_ren",  inst_ren,  1'b1);
    check("redir_addr", inst_addr, 32'h100);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (if_valid) break;
    end
    check("redir_first_valid", if_valid, 1'b1);
    check("redir_first_pc",    if_pc,    32'h100);

    // Redirect coinciding with an ack and a pop; target is misaligned.
    set_lat(0, 0);
    do_reset();
    repeat (4) tick();
    b_redir = 1'b1; b_redir_addr = 32'h203;
    tick();
    check("pre_ack",   inst_ack, 1'b1);
    check("pre_valid", if_valid, 1'b1);
    tick();
    check("flush_valid", if_valid,  1'b0);
    check("flush_ren",   inst_ren,  1'b1);
    check("flush_addr",  inst_addr, 32'h200);
    tick();
    check("flush_head", if_pc, 32'h200);

    // PC wraps past the top of the address space.
    b_redir = 1'b1; b_redir_addr = 32'hFFFF_FFFC;
    tick();
    tick();
    check("wrap_addr0", inst_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1", inst_addr, 32'h0);

    // cpu_en dropped while a fetch is outstanding.
    set_lat(3, 3);
    b_ready = 1'b0;
    b_redir = 1'b1; b_redir_addr = 32'h300;
    tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      if (inst_ren && inst_addr == 32'h300) break;
    end
    b_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (inst_ack) break;
    end
    check("en_ack", inst_ack, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("en_hold", inst_ren, 1'b0);
    end
    check("en_pushed_valid", if_valid, 1'b1);
    check("en_pushed_pc",    if_pc,    32'h300);
    b_en = 1'b1;
    tick();
    tick();
    check("en_resume_ren",  inst_ren,  1'b1);
    check("en_resume_addr", inst_addr, 32'h304);

    // Asynchronous reset in the middle of an outstanding request.
    #2 cpu_rst = 1'b1;
    #1;
    check("arst_ren",   inst_ren,  1'b0);
    check("arst_addr",  inst_addr, 32'h0);
    check("arst_valid", if_valid,  1'b0);
    check("arst_pc",    if_pc,     32'h0);
    check("arst_inst",  if_inst,   32'h0);

    // Randomized traffic against the stream model.
    set_lat(0, 3);
    b_ready = 1'b1;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      b_en    = ($urandom_range(9, 0) != 0);
      b_ready = ($urandom_range(9, 0) < 7);
      if ($urandom_range(31, 0) == 0) begin
        b_redir      = 1'b1;
        b_redir_addr = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                    : $urandom();
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
